// File: rtl/nanci_sort_ctrl.sv
// nanci_sort_ctrl: shearsort sequencer for a SIDE x SIDE PE mesh.
// Broadcasts row/column compare-exchange opcodes phase by phase.
module nanci_sort_ctrl #(
  parameter int SIDE        = 4,
  parameter int LOG_SIDE    = 2,
  parameter int SORT_CYCLES = 1,
  localparam int PW = $clog2(2*LOG_SIDE+1)+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  output logic [2:0]    o_op,
  output logic          o_load,
  output logic [PW-1:0] o_phase,
  output logic          o_busy,
  output logic          o_done
);

  localparam int NPH = 2*LOG_SIDE+1;
  localparam int HW  = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
  localparam int SW  = (LOG_SIDE > 0) ? LOG_SIDE : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(SORT_CYCLES-1);
  localparam logic [SW-1:0] STEP_LAST = SW'(SIDE-1);
  localparam logic [PW-1:0] PH_LAST   = PW'(NPH-1);

  if (LOG_SIDE < 1 || SIDE != (1 << LOG_SIDE) || SORT_CYCLES < 1)
  begin : g_cfg_err
    $error("nanci_sort_ctrl: inconsistent SIDE/LOG_SIDE/SORT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] step_q, step_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    op_q, op_d;
  logic          load_q, load_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] oph_q, oph_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    step_d  = step_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: begin
        hold_d  = '0;
        step_d  = '0;
        phase_d = '0;
        if (i_start && !i_abort) state_d = LOAD;
      end
      LOAD: begin
        state_d = i_abort ? IDLE : RUN;
        hold_d  = '0;
        step_d  = '0;
        phase_d = '0;
      end
      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
          hold_d  = '0;
          step_d  = '0;
          phase_d = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d = '0;
          if (step_q != STEP_LAST) begin
            step_d = step_q + SW'(1);
          end else begin
            step_d = '0;
            if (phase_q != PH_LAST) begin
              phase_d = phase_q + PW'(1);
            end else begin
              phase_d = '0;
              state_d = DONE;
            end
          end
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    op_d   = 3'd0;
    oph_d  = '0;
    load_d = (state_d == LOAD);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
    if (state_d == RUN) begin
      oph_d = phase_d;
      unique case (1'b1)
        !phase_d[0] && !step_d[0]: op_d = 3'd1;
        !phase_d[0] &&  step_d[0]: op_d = 3'd2;
         phase_d[0] && !step_d[0]: op_d = 3'd3;
         phase_d[0] &&  step_d[0]: op_d = 3'd4;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      step_q  <= '0;
      phase_q <= '0;
      op_q    <= 3'd0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      oph_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      op_q    <= op_d;
      load_q  <= load_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      oph_q   <= oph_d;
    end
  end

  assign o_op    = op_q;
  assign o_load  = load_q;
  assign o_done  = done_q;
  assign o_busy  = busy_q;
  assign o_phase = oph_q;

endmodule

// File: tb/tb_nanci_sort_ctrl.sv
// tb_nanci_sort_ctrl: three configurations driven in lockstep and
// compared each cycle against a position-based sequence model.
module tb_nanci_sort_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_start = 1'b0;
  logic i_abort = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] op_a, op_b, op_c;
  logic       load_a, load_b, load_c;
  logic       done_a, done_b, done_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] ph_a, ph_b;
  logic [3:0] ph_c;

  nanci_sort_ctrl #(.SIDE(2), .LOG_SIDE(1), .SORT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .o_op(op_a), .o_load(load_a), .o_phase(ph_a),
    .o_busy(busy_a), .o_done(done_a));

  nanci_sort_ctrl #(.SIDE(2), .LOG_SIDE(1), .SORT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .o_op(op_b), .o_load(load_b), .o_phase(ph_b),
    .o_busy(busy_b), .o_done(done_b));

  nanci_sort_ctrl #(.SIDE(4), .LOG_SIDE(2), .SORT_CYCLES(1)) u_c (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .o_op(op_c), .o_load(load_c), .o_phase(ph_c),
    .o_busy(busy_c), .o_done(done_c));

  typedef struct packed {
    logic [2:0] op;
    logic       load;
    logic       done;
    logic       busy;
    logic [3:0] ph;
  } rec_t;

  rec_t act [3];
  assign act[0] = {op_a, load_a, done_a, busy_a, 1'b0, ph_a};
  assign act[1] = {op_b, load_b, done_b, busy_b, 1'b0, ph_b};
  assign act[2] = {op_c, load_c, done_c, busy_c, ph_c};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pos [3] = '{-1, -1, -1};

  function automatic int cfg_side(int d);
    return (d == 2) ? 4 : 2;
  endfunction
  function automatic int cfg_log(int d);
    return (d == 2) ? 2 : 1;
  endfunction
  function automatic int cfg_sc(int d);
    return (d == 1) ? 3 : 1;
  endfunction
  function automatic int run_len(int d);
    return (2*cfg_log(d)+1) * cfg_side(d) * cfg_sc(d);
  endfunction

  // pos: -1 idle, 0 load, 1..R run cycle, R+1 done
  function automatic rec_t expect_rec(int d);
    rec_t r;
    int p, k, ph, st;
    r = '0;
    p = pos[d];
    if (p < 0) return r;
    r.busy = 1'b1;
    if (p == 0) begin
      r.load = 1'b1;
    end else if (p == run_len(d) + 1) begin
      r.done = 1'b1;
    end else begin
      k  = p - 1;
      ph = k / (cfg_side(d) * cfg_sc(d));
      st = (k / cfg_sc(d)) % cfg_side(d);
      if (ph % 2 == 0) r.op = (st % 2 == 0) ? 3'd1 : 3'd2;
      else             r.op = (st % 2 == 0) ? 3'd3 : 3'd4;
      r.ph = 4'(ph);
    end
    return r;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      if (pos[d] < 0) begin
        if (i_start && !i_abort) pos[d] = 0;
      end else if (pos[d] <= run_len(d)) begin
        pos[d] = i_abort ? -1 : pos[d] + 1;
      end else begin
        pos[d] = -1;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("model_dut%0d", d), 32'(act[d]), 32'(expect_rec(d)));
  endtask

  typedef struct {
    bit   st;
    bit   ab;
    rec_t exp;
  } vec_t;

  function automatic vec_t mk(bit st, bit ab, int op, bit ld, bit dn,
                              bit bs, int ph);
    vec_t v;
    v.st = st;
    v.ab = ab;
    v.exp = {3'(op), ld, dn, bs, 4'(ph)};
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    int run_c, dones_c, done_b_at, loads;

    tbl[0]  = mk(1, 0, 0, 1, 0, 1, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 2, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 3, 0, 0, 1, 1);
    tbl[4]  = mk(1, 0, 4, 0, 0, 1, 1);
    tbl[5]  = mk(0, 0, 1, 0, 0, 1, 2);
    tbl[6]  = mk(0, 0, 2, 0, 0, 1, 2);
    tbl[7]  = mk(1, 0, 0, 0, 1, 1, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 1, 0, 1, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 0);

    // reset holds everything at zero even with start requested
    i_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_dut%0d", d), 32'(act[d]), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      i_start = tbl[i].st;
      i_abort = tbl[i].ab;
      step();
      chk($sformatf("tbl_row%0d", i), 32'(act[0]), 32'(tbl[i].exp));
    end
    i_start = 1'b0;
    i_abort = 1'b0;
    repeat (3) step();

    // abort in the third RUN cycle
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (3) step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abort_op_c", 32'(op_c), 32'd0);
    chk("abort_busy_c", 32'(busy_c), 32'd0);
    chk("abort_done_c", 32'(done_c), 32'd0);

    // clean full sequence after abort; measure run length and done timing
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    run_c = 0;
    dones_c = 0;
    done_b_at = 0;
    for (int c = 2; c <= 40; c++) begin
      step();
      if (op_c != 3'd0) run_c++;
      if (done_c) dones_c++;
      if (done_b && done_b_at == 0) done_b_at = c;
    end
    chk("runlen_c", 32'(run_c), 32'd20);
    chk("dones_c", 32'(dones_c), 32'd1);
    chk("done_cycle_b", 32'(done_b_at), 32'd20);

    // start held high: back-to-back sorts with one idle cycle between
    i_start = 1'b1;
    loads = 0;
    repeat (80) begin
      step();
      if (load_c) loads++;
    end
    chk("b2b_loads_c", 32'(loads), 32'd4);
    i_start = 1'b0;
    repeat (30) step();

    // asynchronous reset between clock edges mid-RUN
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (5) step();
    #3;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async_rst_dut%0d", d), 32'(act[d]), 32'd0);
      pos[d] = -1;
    end
    step();
    rst = 1'b1;
    repeat (25) step();

    repeat (600) begin
      i_start = ($urandom_range(0, 3) == 0);
      i_abort = ($urandom_range(0, 19) == 0);
      step();
    end
    i_start = 1'b0;
    i_abort = 1'b0;
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
